ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Sequential fetch stage sitting directly upstream of the behavioural memory unit `mem`. It owns the program counter and drives `mem`'s `address` and `read` inputs. It captures `memOut` (combinational read) into a small instruction buffer and presents instructions downstream with a valid/ready handshake. It supports redirects and flags faults for misaligned or out-of-range fetch addresses.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
DEPTH, 2, instruction buffer entries (2..8).
ADDR_LIMIT, 32'h0000FFFF, highest legal fetch address; matches `mem` CAPACITY.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
mem_addr  output  32  to `mem` address; equals pc.
mem_read  output  1  to `mem` read.
mem_rdata  input  32  from `mem` memOut, valid in the same cycle as mem_addr/mem_read.
redirect  input  1  load redirect_pc, flush buffer.
redirect_pc  input  32  new fetch address.
inst_valid  output  1  buffer head valid.
inst_ready  input  1  consumer accepts head.
inst  output  32  head instruction word.
inst_pc  output  32  head instruction address.
fault  output  1  fetch halted on bad address.

Behaviour:
- Reset (async, immediate, no clock needed):
  - pc=RESET_PC, buffer count=0, state=FETCH.
  - inst_valid=0, fault=0, mem_read=0 while reset is high.
  - inst/inst_pc=0 when buffer empty.
- State machine, two states:
  - FETCH -> FAULT when the pc to be fetched is misaligned (pc[1:0]!=0) or pc>ADDR_LIMIT; also on a bad redirect.
  - FAULT -> FETCH only on a redirect with a legal redirect_pc.
  - Reset forces FETCH from either state.
- mem_addr=pc at all times.
  - mem_read=1 iff state=FETCH, not reset, pc legal, redirect=0, and count<DEPTH. Full is evaluated before any same-cycle pop; no fetch-through when full.
- Push: at a posedge with mem_read=1, push {pc, mem_rdata} and set pc=pc+4 (32-bit modulo).
- Pop: at a posedge with inst_valid && inst_ready && !redirect, advance the head.
  - Simultaneous push and pop leave count unchanged.
- inst_valid=(count!=0); inst/inst_pc come from the head (registered FIFO, no combinational path from mem_rdata).
- Redirect has highest priority at a posedge:
  - count=0 (flush, including any same-cycle pop or push), pc=redirect_pc, no push.
  - If redirect_pc is illegal: state=FAULT and fault=1 at that edge.
  - If legal: fault=0 and state=FETCH.
- Fault entry from sequential fetch: at the edge where pc is illegal, enter FAULT, fault=1, and pc holds the offending address.
  - Entries already buffered still drain normally.
- fault stays high until a legal redirect or reset.
- Latency:
  - After reset release, the first fetch occurs at the first posedge; inst_valid rises after that edge.
  - After a redirect edge, inst_valid=0 for one cycle; the first redirected instruction is valid after the next edge.
- Throughput: one instruction per cycle when inst_ready is held high.
- Ordering: strictly program order, with no duplicates or drops except those flushed by a redirect.

Test Plan:
1. Reset with RESET_PC=0 and inst_ready=1 for 6 cycles -> inst_pc sequence 0,4,8,0xC,0x10 on consecutive cycles starting one edge after reset release; inst equals the `mem` word at each address.
2. inst_ready=0 for 5 cycles after reset -> count reaches 2, mem_read=0, pc=8. Raise inst_ready -> inst_pc 0,4,8,0xC delivered with no gaps or duplicates.
3. Buffer full, pulse redirect with redirect_pc=0x28 -> inst_valid=0 the next cycle. The following cycle inst_pc=0x28 with inst = word at 0x28, then 0x2C, 0x30.
4. Redirect to 0x2A -> fault=1, inst_valid=0, mem_read=0 for 4 cycles. Then redirect to 0x30 -> fault=0 and inst_pc=0x30 valid two edges later.
5. Redirect to 0xFFF8 with inst_ready=1 -> 0xFFF8 and 0xFFFC delivered, then fault=1 with pc=0x10000 and no further pushes.
6. Assert reset asynchronously mid-stream (between clock edges, count=2) -> inst_valid=0, fault=0, mem_read=0 immediately. After release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch stage in front of the behavioural
// memory `mem`. Owns the program counter, issues one combinational read per
// cycle, buffers {pc, word} pairs in a small FIFO and presents them downstream
// with a valid/ready handshake. Redirects flush the buffer and reload the pc;
// misaligned or out-of-range fetch addresses halt fetching with a sticky fault.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   mem_addr, mem_read  read request to `mem` (mem_addr always equals pc)
//   mem_rdata           word returned by `mem` in the same cycle
//   redirect, redirect_pc  flush and restart fetch at redirect_pc
//   inst_valid, inst_ready, inst, inst_pc  downstream instruction handshake
//   fault               fetch halted on an illegal address
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc, pc_nxt;
  logic [31:0]     buf_pc   [DEPTH];
  logic [31:0]     buf_data [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            pc_legal, redir_legal, full, push, pop;

  // Wrapping pointer increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pc_legal    = (pc[1:0] == 2'b00) && (pc <= ADDR_LIMIT);
  assign redir_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= ADDR_LIMIT);
  assign full        = (count == CW'(DEPTH));
  assign push        = mem_read;
  assign pop         = inst_valid && inst_ready && !redirect;

  // State and pc register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next state, next pc and read request; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    mem_read  = 1'b0;
    if (redirect) begin
      pc_nxt    = redirect_pc;
      state_nxt = redir_legal ? S_FETCH : S_FAULT;
    end else begin
      case (state)
        S_FETCH: begin
          if (!pc_legal) begin
            state_nxt = S_FAULT;
          end else if (!full && !reset) begin
            mem_read = 1'b1;
            pc_nxt   = pc + 32'd4;
          end
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
        default: begin
          state_nxt = S_FETCH;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; redirect flushes regardless of push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[tail]   <= pc;
      buf_data[tail] <= mem_rdata;
    end
  end

  assign mem_addr   = pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? buf_data[head] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc[head]   : 32'h0;
  assign fault      = (state == S_FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural `mem` model, an expected
// instruction queue filled by the stimulus and a negedge monitor that checks
// every instruction the consumer accepts.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Distinct, address-dependent memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .ADDR_LIMIT(32'h0000_FFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .fault      (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.word = mem_word(p);
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every instruction accepted by the consumer must match the queue head.
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    step(2);

    // 1: streaming from RESET_PC
    for (int i = 0; i < 5; i++) expect_pc(32'(4 * i));
    reset = 1'b0;
    step(6);
    inst_ready = 1'b0;

    // 2: back-pressure fills the buffer, then drains in order
    reset = 1'b1;
    #1;
    check("rst2_inst_valid", 32'(inst_valid), 32'd0);
    check("rst2_mem_read", 32'(mem_read), 32'd0);
    check("rst2_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(5);
    check("full_inst_valid", 32'(inst_valid), 32'd1);
    check("full_mem_read", 32'(mem_read), 32'd0);
    check("full_pc", mem_addr, 32'h8);
    check("full_head_pc", inst_pc, 32'h0);
    for (int i = 0; i < 4; i++) expect_pc(32'(4 * i));
    inst_ready = 1'b1;
    step(4);
    inst_ready = 1'b0;

    // 3: redirect while full
    step(1);
    check("full2_mem_read", 32'(mem_read), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h28;
    step(1);
    redirect = 1'b0;
    check("redir_inst_valid", 32'(inst_valid), 32'd0);
    check("redir_mem_addr", mem_addr, 32'h28);
    check("redir_fault", 32'(fault), 32'd0);
    expect_pc(32'h28);
    expect_pc(32'h2C);
    expect_pc(32'h30);
    inst_ready = 1'b1;
    step(4);
    inst_ready = 1'b0;

    // 4: misaligned redirect faults, legal redirect recovers
    redirect    = 1'b1;
    redirect_pc = 32'h2A;
    #1;
    check("redir_blocks_read", 32'(mem_read), 32'd0);
    step(1);
    redirect = 1'b0;
    check("bad_redir_addr", mem_addr, 32'h2A);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fault_hold", 32'(fault), 32'd1);
      check("fault_inst_valid", 32'(inst_valid), 32'd0);
      check("fault_mem_read", 32'(mem_read), 32'd0);
      step(1);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h30;
    inst_ready  = 1'b1;
    expect_pc(32'h30);
    step(1);
    redirect = 1'b0;
    #1;
    check("recover_fault", 32'(fault), 32'd0);
    check("recover_inst_valid", 32'(inst_valid), 32'd0);
    step(2);
    inst_ready = 1'b0;

    // 5: fetch runs off the top of memory
    redirect    = 1'b1;
    redirect_pc = 32'hFFF8;
    inst_ready  = 1'b1;
    expect_pc(32'hFFF8);
    expect_pc(32'hFFFC);
    step(1);
    redirect = 1'b0;
    step(2);
    check("oob_mem_read", 32'(mem_read), 32'd0);
    check("oob_pc", mem_addr, 32'h0001_0000);
    check("oob_fault_pre", 32'(fault), 32'd0);
    step(1);
    check("oob_fault", 32'(fault), 32'd1);
    check("oob_pc_hold", mem_addr, 32'h0001_0000);
    check("oob_inst_valid", 32'(inst_valid), 32'd0);
    step(2);
    check("oob_no_push", 32'(inst_valid), 32'd0);
    check("oob_fault_sticky", 32'(fault), 32'd1);
    inst_ready = 1'b0;

    // 6: asynchronous reset mid-stream with a full buffer
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step(1);
    redirect = 1'b0;
    step(2);
    check("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
    check("pre_rst_mem_read", 32'(mem_read), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_inst_valid", 32'(inst_valid), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_mem_read", 32'(mem_read), 32'd0);
    check("async_inst_pc", inst_pc, 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    inst_ready = 1'b1;
    expect_pc(32'h0);
    expect_pc(32'h4);
    step(3);
    inst_ready = 1'b0;

    step(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
